// File: rtl/fifo_ring.sv
// fifo_ring: single-clock circular-buffer FIFO with occupancy count,
// threshold flags, sticky error flags and a selectable read mode.
//
// Ports
//   clock         rising-edge clock
//   resetn        synchronous active-low reset
//   flush         synchronous clear of contents (error flags untouched)
//   write_enable  push request, data_in = push data
//   read_enable   pop request
//   data_out      popped word (FWFT=0) or head word (FWFT=1)
//   data_valid    data_out holds a valid word
//   full, empty, almost_full, almost_empty   decodes of count
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: push requested but rejected
//   underflow     sticky: pop requested but rejected
//   clear_errors  clears overflow/underflow (a same-cycle new error wins)
module fifo_ring #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  parameter int FWFT         = 0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       write_enable,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       read_enable,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clear_errors
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;

  logic pop_ok, push_ok, push_acc, pop_acc;

  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AFULL_C);
    almost_empty = (count_q <= AEMPTY_C);
  end

  always_comb begin
    pop_ok   = read_enable && !empty;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    push_ok  = write_enable && (!full || pop_ok);
    push_acc = push_ok && !flush && resetn;
    pop_acc  = pop_ok && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (pop_ok) begin
        dout_d   = mem_q[rd_ptr_q];
        dvalid_d = 1'b1;
      end
    end

    // Flush suppresses new error events; set has priority over clear.
    overflow_d  = (!flush && write_enable && !push_ok) || (overflow_q && !clear_errors);
    underflow_d = (!flush && read_enable && !pop_ok)   || (underflow_q && !clear_errors);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push_acc) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
    end
  end

  // In FWFT mode the head slot is shown directly; it reads as zero when empty
  // so the output is defined after reset without touching storage.
  always_comb begin
    if (FWFT != 0) begin
      data_out   = empty ? '0 : mem_q[rd_ptr_q];
      data_valid = !empty;
    end else begin
      data_out   = dout_q;
      data_valid = dvalid_q;
    end
    count     = count_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

  logic unused_acc;
  assign unused_acc = pop_acc;

endmodule

// File: tb/tb_fifo_ring.sv
module tb_fifo_ring;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enable = 1'b0;
  logic       clear_errors = 1'b0;

  logic [7:0] dout [3];
  logic       dv [3];
  logic       full [3];
  logic       empty [3];
  logic       af [3];
  logic       ae [3];
  logic [2:0] cnt [3];
  logic       ovf [3];
  logic       unf [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // instance 0: DEPTH=4 registered read; 1: DEPTH=5 registered read; 2: DEPTH=4 FWFT
  fifo_ring #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_d4 (
    .clock(clock), .resetn(resetn), .flush(flush), .write_enable(write_enable),
    .data_in(data_in), .read_enable(read_enable), .data_out(dout[0]), .data_valid(dv[0]),
    .full(full[0]), .empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]),
    .count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0]), .clear_errors(clear_errors));

  fifo_ring #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_d5 (
    .clock(clock), .resetn(resetn), .flush(flush), .write_enable(write_enable),
    .data_in(data_in), .read_enable(read_enable), .data_out(dout[1]), .data_valid(dv[1]),
    .full(full[1]), .empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]),
    .count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1]), .clear_errors(clear_errors));

  fifo_ring #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fw (
    .clock(clock), .resetn(resetn), .flush(flush), .write_enable(write_enable),
    .data_in(data_in), .read_enable(read_enable), .data_out(dout[2]), .data_valid(dv[2]),
    .full(full[2]), .empty(empty[2]), .almost_full(af[2]), .almost_empty(ae[2]),
    .count(cnt[2]), .overflow(ovf[2]), .underflow(unf[2]), .clear_errors(clear_errors));

  // Behavioural model: contents kept as an ordered list, head at index 0.
  int         mdepth [3] = '{4, 5, 4};
  int         mfwft  [3] = '{0, 0, 1};
  logic [7:0] mdata  [3][8];
  int         mcnt   [3] = '{0, 0, 0};
  logic       movf   [3] = '{0, 0, 0};
  logic       munf   [3] = '{0, 0, 0};
  logic [7:0] mdo    [3] = '{0, 0, 0};
  logic       mdv    [3] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (!resetn) begin
        mcnt[k] = 0; movf[k] = 0; munf[k] = 0; mdo[k] = 0; mdv[k] = 0;
      end else if (flush) begin
        mcnt[k] = 0; mdv[k] = 0;
        movf[k] = movf[k] && !clear_errors;
        munf[k] = munf[k] && !clear_errors;
      end else begin
        logic pop, push;
        logic [7:0] popped;
        popped = 8'h00;
        pop  = read_enable && (mcnt[k] > 0);
        push = write_enable && ((mcnt[k] < mdepth[k]) || pop);
        if (pop) begin
          popped = mdata[k][0];
          for (int i = 0; i < 7; i++) mdata[k][i] = mdata[k][i+1];
          mcnt[k] = mcnt[k] - 1;
        end
        if (push) begin
          mdata[k][mcnt[k]] = data_in;
          mcnt[k] = mcnt[k] + 1;
        end
        movf[k] = (write_enable && !push) || (movf[k] && !clear_errors);
        munf[k] = (read_enable && !pop)   || (munf[k] && !clear_errors);
        mdv[k] = pop;
        if (pop) mdo[k] = popped;
      end
    end
  endtask

  // Compare process: every cycle, shortly after the rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
        logic [7:0] e_do;
        logic       e_dv;
        e_dv = (mfwft[k] != 0) ? (mcnt[k] > 0) : mdv[k];
        e_do = (mfwft[k] != 0) ? ((mcnt[k] > 0) ? mdata[k][0] : 8'h00) : mdo[k];
        chk($sformatf("i%0d_count", k), 32'(cnt[k]), 32'(mcnt[k]));
        chk($sformatf("i%0d_full", k), 32'(full[k]), 32'(mcnt[k] == mdepth[k]));
        chk($sformatf("i%0d_empty", k), 32'(empty[k]), 32'(mcnt[k] == 0));
        chk($sformatf("i%0d_afull", k), 32'(af[k]), 32'(mcnt[k] >= mdepth[k] - 2));
        chk($sformatf("i%0d_aempty", k), 32'(ae[k]), 32'(mcnt[k] <= 2));
        chk($sformatf("i%0d_ovf", k), 32'(ovf[k]), 32'(movf[k]));
        chk($sformatf("i%0d_unf", k), 32'(unf[k]), 32'(munf[k]));
        chk($sformatf("i%0d_dvalid", k), 32'(dv[k]), 32'(e_dv));
        chk($sformatf("i%0d_dout", k), 32'(dout[k]), 32'(e_do));
      end
    end
  end

  // One clock cycle of stimulus; called and returns on a falling edge.
  task automatic cyc(input logic we, input logic [7:0] d, input logic re,
                     input logic fl = 1'b0, input logic clr = 1'b0, input logic rst_n = 1'b1);
    write_enable = we;
    data_in      = d;
    read_enable  = re;
    flush        = fl;
    clear_errors = clr;
    resetn       = rst_n;
    @(posedge clock);
    model_step();
    @(negedge clock);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    flush        = 1'b0;
    clear_errors = 1'b0;
  endtask

  initial begin
    int e;
    @(negedge clock);
    // reset with push/pop requests held: all must be ignored
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(cnt[0]), 32'd0);
    chk("rst_empty", 32'(empty[0]), 32'd1);
    chk("rst_aempty", 32'(ae[0]), 32'd1);
    chk("rst_afull", 32'(af[0]), 32'd0);
    chk("rst_dout", 32'(dout[0]), 32'h00);
    chk("rst_dvalid", 32'(dv[0]), 32'd0);
    chk("rst_ovf", 32'(ovf[0]), 32'd0);

    // ordered read-back, registered read
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    chk("a_count3", 32'(cnt[0]), 32'd3);
    chk("a_fwft_head", 32'(dout[2]), 32'h11);
    cyc(1'b0, 8'h00, 1'b1);
    chk("a_pop1", 32'(dout[0]), 32'h11);
    chk("a_pop1_v", 32'(dv[0]), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("a_pop2", 32'(dout[0]), 32'h22);
    cyc(1'b0, 8'h00, 1'b1);
    chk("a_pop3", 32'(dout[0]), 32'h33);
    chk("a_pop3_v", 32'(dv[0]), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("a_empty", 32'(empty[0]), 32'd1);
    chk("a_idle_v", 32'(dv[0]), 32'd0);
    chk("a_hold", 32'(dout[0]), 32'h33);

    // full, overflow, push+pop while full
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("b_full", 32'(full[0]), 32'd1);
    cyc(1'b1, 8'h99, 1'b0);
    chk("b_ovf", 32'(ovf[0]), 32'd1);
    chk("b_count4", 32'(cnt[0]), 32'd4);
    chk("b_d5_full", 32'(full[1]), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("b_ovf_clr", 32'(ovf[0]), 32'd0);
    cyc(1'b1, 8'h55, 1'b1);
    chk("b_pp_count", 32'(cnt[0]), 32'd4);
    chk("b_pp_full", 32'(full[0]), 32'd1);
    chk("b_pp_ovf", 32'(ovf[0]), 32'd0);
    chk("b_pp_dout", 32'(dout[0]), 32'h01);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("b_drain_last", 32'(dout[0]), 32'h55);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // underflow behaviour
    cyc(1'b0, 8'h00, 1'b1);
    chk("c_unf", 32'(unf[0]), 32'd1);
    chk("c_count0", 32'(cnt[0]), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("c_unf_clr", 32'(unf[0]), 32'd0);
    cyc(1'b1, 8'h66, 1'b1);
    chk("c_pp_count", 32'(cnt[0]), 32'd1);
    chk("c_pp_unf", 32'(unf[0]), 32'd1);
    chk("c_pp_nov", 32'(dv[0]), 32'd0);
    // clear coincident with a new underflow: set wins
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("c_set_wins", 32'(unf[0]), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // DEPTH=5 wrap: 1..12 streamed through
    e = 1;
    for (int v = 1; v <= 12; v++) begin
      cyc(1'b1, 8'(v), v > 3);
      if (v > 3) begin
        chk("d_order", 32'(dout[1]), 32'(e));
        e++;
      end
      chk("d_cnt_le5", 32'(cnt[1] <= 3'd5), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("d_order", 32'(dout[1]), 32'(e));
      e++;
    end
    chk("d_empty", 32'(empty[1]), 32'd1);
    // fill DEPTH=5 past the wrap point, then drain
    for (int v = 20; v < 26; v++) cyc(1'b1, 8'(v), 1'b0);
    chk("d_full5", 32'(full[1]), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("d_last", 32'(dout[1]), 32'd24);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // FWFT latency
    chk("e_pre_v", 32'(dv[2]), 32'd0);
    cyc(1'b1, 8'hA5, 1'b0);
    chk("e_fw_dout", 32'(dout[2]), 32'hA5);
    chk("e_fw_v", 32'(dv[2]), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("e_fw_v0", 32'(dv[2]), 32'd0);

    // flush then reset mid-stream
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h04, 1'b1, 1'b1);
    chk("f_fl_count", 32'(cnt[0]), 32'd0);
    chk("f_fl_empty", 32'(empty[0]), 32'd1);
    chk("f_fl_v", 32'(dv[0]), 32'd0);
    chk("f_fl_unf", 32'(unf[0]), 32'd1);
    cyc(1'b1, 8'h05, 1'b0);
    cyc(1'b1, 8'h06, 1'b1);
    cyc(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("f_rst_count", 32'(cnt[0]), 32'd0);
    chk("f_rst_empty", 32'(empty[0]), 32'd1);
    chk("f_rst_unf", 32'(unf[0]), 32'd0);
    chk("f_rst_v", 32'(dv[2]), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
